tdm_demux4: RTL and testbench

Receive-side counterpart to the 4:1 nibble mux path. It takes a time-division-multiplexed stream of WIDTH-bit beats, tagged with valid and start-of-frame, and distributes the beats into four registered channel outputs. A complete frame is presented atomically with a one-cycle frame_valid strobe. It sits at the far end of the TDM link, feeding per-channel consumers.

---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_slot_ctr.sv | 27 ++
 rtl/tdm_demux4.sv | 133 +++++++++++++
 tb/tb_tdm_demux4.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 2'd3;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clears on reset, loads 1 on a start of frame,
// otherwise increments with natural wrap from 3 back to 0.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  // Load takes priority over increment so a resync always restarts at slot 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
    end else if (load) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + 1'b1;
    end
  end

  assign last = (slot == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side TDM demux: gathers four beats of a frame into shadow
// registers and publishes them to the channel outputs all at once.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err
);

  state_t state;
  state_t state_next;

  logic              ctr_load;
  logic              ctr_inc;
  logic              slot_last;
  logic              shadow_we;
  logic [SLOT_W-1:0] shadow_idx;
  logic              out_we;
  logic              fv_next;
  logic              se_next;

  logic [WIDTH-1:0]  shadow0;
  logic [WIDTH-1:0]  shadow1;
  logic [WIDTH-1:0]  shadow2;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .inc   (ctr_inc),
    .slot  (slot),
    .last  (slot_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control; an SOF always restarts capture at slot 0.
  always_comb begin
    state_next = state;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    shadow_we  = 1'b0;
    out_we     = 1'b0;
    fv_next    = 1'b0;
    se_next    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_sof) begin
          ctr_load   = 1'b1;
          shadow_we  = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (in_sof) begin
            se_next   = 1'b1;
            ctr_load  = 1'b1;
            shadow_we = 1'b1;
          end else if (slot_last) begin
            out_we     = 1'b1;
            fv_next    = 1'b1;
            ctr_inc    = 1'b1;
            state_next = IDLE;
          end else begin
            ctr_inc   = 1'b1;
            shadow_we = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign shadow_idx = ctr_load ? '0 : slot;

  // Shadow capture of slots 0..2; slot 3 goes straight to out3.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow0 <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
    end else if (shadow_we) begin
      case (shadow_idx)
        2'd0:    shadow0 <= in_data;
        2'd1:    shadow1 <= in_data;
        2'd2:    shadow2 <= in_data;
        default: ;
      endcase
    end
  end

  // Channel outputs update together on the last beat; strobes last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= fv_next;
      sync_err    <= se_next;
      if (out_we) begin
        out0 <= shadow0;
        out1 <= shadow1;
        out2 <= shadow2;
        out3 <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus random
// traffic, compared every cycle against a queue-based frame model.
module tb_tdm_demux4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_sof;
  logic [3:0] in_data;
  logic [3:0] out0;
  logic [3:0] out1;
  logic [3:0] out2;
  logic [3:0] out3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       sync_err;

  int errCount   = 0;
  int checkCount = 0;
  bit checkOn    = 0;

  logic [3:0] mq[$];
  logic [3:0] mOut[4];
  bit         mFv;
  bit         mSe;

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .sync_err    (sync_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: a frame is the list of beats collected since the last SOF.
  always @(posedge clk) begin
    mFv = 0;
    mSe = 0;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 4; i++) mOut[i] = '0;
    end else if (in_valid) begin
      if (in_sof) begin
        if (mq.size() > 0) mSe = 1;
        mq.delete();
        mq.push_back(in_data);
      end else if (mq.size() > 0) begin
        mq.push_back(in_data);
        if (mq.size() == 4) begin
          for (int i = 0; i < 4; i++) mOut[i] = mq[i];
          mFv = 1;
          mq.delete();
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("cyc_out0", 32'(out0), 32'(mOut[0]));
      checkOutput("cyc_out1", 32'(out1), 32'(mOut[1]));
      checkOutput("cyc_out2", 32'(out2), 32'(mOut[2]));
      checkOutput("cyc_out3", 32'(out3), 32'(mOut[3]));
      checkOutput("cyc_fv",   32'(frame_valid), 32'(mFv));
      checkOutput("cyc_se",   32'(sync_err), 32'(mSe));
      checkOutput("cyc_slot", 32'(slot), 32'(mq.size()));
      checkOutput("cyc_excl", 32'(frame_valid & sync_err), 32'd0);
    end
  end

  initial begin
    reset    = 1;
    in_valid = 0;
    in_sof   = 0;
    in_data  = 0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOn = 1;
    checkOutput("rst_out0", 32'(out0), 32'd0);
    checkOutput("rst_slot", 32'(slot), 32'd0);
    checkOutput("rst_fv",   32'(frame_valid), 32'd0);

    // Basic frame
    applyStimulus(0, 1, 1, 4'hA);
    applyStimulus(0, 1, 0, 4'hB);
    applyStimulus(0, 1, 0, 4'hC);
    applyStimulus(0, 1, 0, 4'hD);
    applyStimulus(0, 0, 0, 0);
    checkOutput("basic_fv",   32'(frame_valid), 32'd1);
    checkOutput("basic_outs", {16'd0, out0, out1, out2, out3}, 32'h0000ABCD);
    checkOutput("basic_slot", 32'(slot), 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("basic_fv_off", 32'(frame_valid), 32'd0);

    // Gapped frame
    applyStimulus(0, 1, 1, 4'h0);
    applyStimulus(0, 1, 0, 4'h1);
    applyStimulus(0, 0, 0, 4'hF);
    applyStimulus(0, 0, 1, 4'hF);
    checkOutput("gap_hold", {16'd0, out0, out1, out2, out3}, 32'h0000ABCD);
    checkOutput("gap_slot", 32'(slot), 32'd2);
    applyStimulus(0, 1, 0, 4'h2);
    applyStimulus(0, 1, 0, 4'h3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("gap_outs", {16'd0, out0, out1, out2, out3}, 32'h00000123);
    checkOutput("gap_fv",   32'(frame_valid), 32'd1);

    // Resync
    applyStimulus(0, 1, 1, 4'hA);
    applyStimulus(0, 1, 0, 4'hB);
    applyStimulus(0, 1, 1, 4'h5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("resync_se",   32'(sync_err), 32'd1);
    checkOutput("resync_hold", {16'd0, out0, out1, out2, out3}, 32'h00000123);
    checkOutput("resync_slot", 32'(slot), 32'd1);
    applyStimulus(0, 1, 0, 4'h6);
    checkOutput("resync_se_off", 32'(sync_err), 32'd0);
    applyStimulus(0, 1, 0, 4'h7);
    applyStimulus(0, 1, 0, 4'h8);
    applyStimulus(0, 0, 0, 0);
    checkOutput("resync_outs", {16'd0, out0, out1, out2, out3}, 32'h00005678);
    checkOutput("resync_fv",   32'(frame_valid), 32'd1);

    // Pre-sync garbage after reset
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 4'h9);
    applyStimulus(0, 1, 0, 4'h9);
    applyStimulus(0, 0, 0, 0);
    checkOutput("garbage_slot", 32'(slot), 32'd0);
    checkOutput("garbage_se",   32'(sync_err), 32'd0);
    applyStimulus(0, 1, 1, 4'h1);
    applyStimulus(0, 1, 0, 4'h2);
    applyStimulus(0, 1, 0, 4'h3);
    applyStimulus(0, 1, 0, 4'h4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("garbage_outs", {16'd0, out0, out1, out2, out3}, 32'h00001234);

    // Back-to-back frames
    applyStimulus(0, 1, 1, 4'hA);
    applyStimulus(0, 1, 0, 4'hB);
    applyStimulus(0, 1, 0, 4'hC);
    applyStimulus(0, 1, 0, 4'hD);
    applyStimulus(0, 1, 1, 4'h0);
    checkOutput("b2b_fv1",   32'(frame_valid), 32'd1);
    checkOutput("b2b_outs1", {16'd0, out0, out1, out2, out3}, 32'h0000ABCD);
    applyStimulus(0, 1, 0, 4'h1);
    applyStimulus(0, 1, 0, 4'h2);
    applyStimulus(0, 1, 0, 4'h3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("b2b_fv2",   32'(frame_valid), 32'd1);
    checkOutput("b2b_outs2", {16'd0, out0, out1, out2, out3}, 32'h00000123);

    // Reset mid-frame
    applyStimulus(0, 1, 1, 4'hA);
    applyStimulus(0, 1, 0, 4'hB);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 4'hC);
    applyStimulus(0, 1, 0, 4'hD);
    applyStimulus(0, 0, 0, 0);
    checkOutput("midrst_outs", {16'd0, out0, out1, out2, out3}, 32'h00000000);
    checkOutput("midrst_slot", 32'(slot), 32'd0);
    checkOutput("midrst_fv",   32'(frame_valid), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 2),
                    4'($urandom));
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
